// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. Collects a little-endian byte stream
// into 32-bit words and writes each word into instruction memory. Words go to
// consecutive addresses starting at BASE_ADDR. The fetch/decode core is held in
// reset until the requested number of words has been written.
//
// Parameters
//   AWIDTH     memory address width
//   DWIDTH     memory data width (fixed at 32, four byte lanes)
//   BASE_ADDR  address of the first loaded word
//   MAX_WORDS  largest legal load length
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   start_i     one-cycle pulse requesting a load session
//   len_i       number of words to load, sampled when a start is accepted
//   byte_i      program byte stream
//   byte_vld_i  byte_i is valid
//   byte_rdy_o  loader accepts a byte this cycle
//   mem_addr_o  instruction memory write address
//   mem_data_o  instruction memory write data
//   mem_wren_o  instruction memory write strobe
//   core_rst_o  hold-in-reset for fetch/decode, active high
//   busy_o      a load session is in progress
//   done_o      load completed, core released
//   err_o       illegal length requested
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [15:0]       len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_vld_i,
  output logic              byte_rdy_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_wren_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       len_q;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [AWIDTH-1:0] addr_off;
  logic              start_ok;
  logic              byte_acc;
  logic              last_byte;
  logic              last_word;

  // A start is only honoured while no session is running.
  assign start_ok  = start_i &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign byte_acc  = byte_vld_i && byte_rdy_o;
  assign last_byte = byte_acc && (byte_cnt == 2'd3);
  assign last_word = (word_cnt + 16'd1) == len_q;
  // Byte offset of the current word; wraps modulo 2^AWIDTH when added to BASE_ADDR.
  assign addr_off  = AWIDTH'({word_cnt, 2'b00});

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          if (len_i == 16'd0) begin
            state_nxt = S_DONE;
          end else if ({16'd0, len_i} > MAX_WORDS) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (last_byte) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        state_nxt = last_word ? S_DONE : S_COLLECT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    byte_rdy_o = 1'b0;
    mem_wren_o = 1'b0;
    core_rst_o = 1'b1;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state)
      S_COLLECT: begin
        byte_rdy_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_WRITE: begin
        mem_wren_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_DONE: begin
        core_rst_o = 1'b0;
        done_o     = 1'b1;
      end
      S_ERR: begin
        err_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Session counters and the registered write port. Address and data are
  // loaded on the edge that enters WRITE and then hold until the next word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= 16'd0;
      word_cnt   <= 16'd0;
      byte_cnt   <= 2'd0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= len_i;
        word_cnt <= 16'd0;
        byte_cnt <= 2'd0;
      end
      // Two-bit counter wraps to 0 on the fourth accepted byte.
      if (byte_acc) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (last_byte) begin
        mem_addr_o <= BASE_ADDR + addr_off;
        mem_data_o <= {byte_i, word_buf};
      end
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  // Lower three byte lanes of the word being assembled. No reset needed:
  // every lane is rewritten before it is used, since byte_cnt restarts at 0.
  always_ff @(posedge clk) begin
    if (byte_acc) begin
      case (byte_cnt)
        2'd0:    word_buf[7:0]   <= byte_i;
        2'd1:    word_buf[15:8]  <= byte_i;
        2'd2:    word_buf[23:16] <= byte_i;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] BASE4 = 32'h0100_0004;

  // Expected flag vectors: {byte_rdy, wren, core_rst, busy, done, err}
  localparam logic [5:0] C_IDLE = 6'b001000;
  localparam logic [5:0] C_COL  = 6'b101100;
  localparam logic [5:0] C_WR   = 6'b011100;
  localparam logic [5:0] C_DONE = 6'b000010;
  localparam logic [5:0] C_ERR  = 6'b001001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] len_i;
  logic [7:0]  byte_i;
  logic        byte_vld_i;
  logic        byte_rdy_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_wren_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_cmp    = 0;
  int n_fail   = 0;
  int wr_count = 0;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .len_i      (len_i),
    .byte_i     (byte_i),
    .byte_vld_i (byte_vld_i),
    .byte_rdy_o (byte_rdy_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wren_o (mem_wren_o),
    .core_rst_o (core_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren_o === 1'b1) wr_count++;
  end

  typedef struct {
    int          s;
    int          l;
    int          b;
    int          v;
    logic [5:0]  fl;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int s, input int l, input int b, input int v,
                     input logic [5:0] fl, input logic [31:0] a, input logic [31:0] d);
    vec_t x;
    x.s = s; x.l = l; x.b = b; x.v = v; x.fl = fl; x.a = a; x.d = d;
    vt.push_back(x);
  endtask

  function automatic logic [69:0] obs();
    return {byte_rdy_o, mem_wren_o, core_rst_o, busy_o, done_o, err_o, mem_addr_o, mem_data_o};
  endfunction

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs for one clock edge, then observe 1 time unit after it.
  task automatic step(input int s, input int l, input int b, input int v);
    start_i    = s[0];
    len_i      = l[15:0];
    byte_i     = b[7:0];
    byte_vld_i = v[0];
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    byte_vld_i = 1'b0;
  endtask

  task automatic sc(input string nm, input int s, input int l, input int b, input int v,
                    input logic [5:0] fl, input logic [31:0] a, input logic [31:0] d);
    step(s, l, b, v);
    chk(nm, obs(), {fl, a, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s2b [4];
    int         wr_before;
    logic [5:0] efl;
    logic [31:0] ed;

    s2b = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst        = 1'b1;
    start_i    = 1'b0;
    len_i      = 16'd0;
    byte_i     = 8'h00;
    byte_vld_i = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("reset_async", obs(), {C_IDLE, 32'h0, 32'h0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Two-word load, byte_vld held high (93 waits out the WRITE cycle)
    add(1, 2,    'h00, 0, C_COL,  32'h0, 32'h0);
    add(0, 0,    'h13, 1, C_COL,  32'h0, 32'h0);
    add(0, 0,    'h00, 1, C_COL,  32'h0, 32'h0);
    add(0, 0,    'h00, 1, C_COL,  32'h0, 32'h0);
    add(0, 0,    'h00, 1, C_WR,   BASE,  32'h0000_0013);
    add(0, 0,    'h93, 1, C_COL,  BASE,  32'h0000_0013);
    add(0, 0,    'h93, 1, C_COL,  BASE,  32'h0000_0013);
    add(0, 0,    'h00, 1, C_COL,  BASE,  32'h0000_0013);
    add(0, 0,    'h10, 1, C_COL,  BASE,  32'h0000_0013);
    add(0, 0,    'h00, 1, C_WR,   BASE4, 32'h0010_0093);
    add(0, 0,    'h00, 0, C_DONE, BASE4, 32'h0010_0093);
    // Bytes outside COLLECT are ignored
    add(0, 0,    'h55, 1, C_DONE, BASE4, 32'h0010_0093);
    // Over-length request, error is sticky, cleared by len=0 start
    add(1, 1025, 'h00, 0, C_ERR,  BASE4, 32'h0010_0093);
    add(0, 0,    'h00, 1, C_ERR,  BASE4, 32'h0010_0093);
    add(1, 0,    'h00, 0, C_DONE, BASE4, 32'h0010_0093);
    add(1, 1025, 'h00, 0, C_ERR,  BASE4, 32'h0010_0093);
    // Error cleared by len=1 start, which then loads normally
    add(1, 1,    'h00, 0, C_COL,  BASE4, 32'h0010_0093);
    add(0, 0,    'hAA, 1, C_COL,  BASE4, 32'h0010_0093);
    add(0, 0,    'hBB, 1, C_COL,  BASE4, 32'h0010_0093);
    add(0, 0,    'hCC, 1, C_COL,  BASE4, 32'h0010_0093);
    add(0, 0,    'hDD, 1, C_WR,   BASE,  32'hDDCC_BBAA);
    add(0, 0,    'h00, 0, C_DONE, BASE,  32'hDDCC_BBAA);
    // Largest legal length is accepted
    add(1, 1024, 'h00, 0, C_COL,  BASE,  32'hDDCC_BBAA);
    add(0, 0,    'h00, 0, C_COL,  BASE,  32'hDDCC_BBAA);

    for (int i = 0; i < vt.size(); i++) begin
      sc($sformatf("vec%0d", i), vt[i].s, vt[i].l, vt[i].b, vt[i].v, vt[i].fl, vt[i].a, vt[i].d);
    end

    // Reset in the middle of a word: two bytes in, then rst low mid-cycle
    sc("s5_b0", 0, 0, 'h01, 1, C_COL, BASE, 32'hDDCC_BBAA);
    sc("s5_b1", 0, 0, 'h02, 1, C_COL, BASE, 32'hDDCC_BBAA);
    wr_before = wr_count;
    #2 rst = 1'b0;
    #1;
    chk("s5_async_reset", obs(), {C_IDLE, 32'h0, 32'h0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sc("s5_idle_hold", 0, 0, 'h77, 1, C_IDLE, 32'h0, 32'h0);
    // Zero-length start from IDLE
    sc("s3_len0", 1, 0, 'h00, 0, C_DONE, 32'h0, 32'h0);
    chk("s5_s3_no_write", 70'(wr_count), 70'(wr_before));
    sc("s5_restart", 1, 1, 'h00, 0, C_COL, 32'h0, 32'h0);
    sc("s5_r0", 0, 0, 'h05, 1, C_COL, 32'h0, 32'h0);
    sc("s5_r1", 0, 0, 'h06, 1, C_COL, 32'h0, 32'h0);
    sc("s5_r2", 0, 0, 'h07, 1, C_COL, 32'h0, 32'h0);
    sc("s5_r3", 0, 0, 'h08, 1, C_WR,  BASE, 32'h0807_0605);
    sc("s5_done", 0, 0, 'h00, 0, C_DONE, BASE, 32'h0807_0605);

    // byte_vld toggling each cycle, len=1
    sc("s2_start", 1, 1, 'h00, 0, C_COL, BASE, 32'h0807_0605);
    for (int i = 0; i < 8; i++) begin
      efl = (i < 6) ? C_COL : ((i == 6) ? C_WR : C_DONE);
      ed  = (i < 6) ? 32'h0807_0605 : 32'h4433_2211;
      sc($sformatf("s2_cyc%0d", i), 0, 0, ((i % 2) == 0) ? int'(s2b[i / 2]) : 'hFF,
         ((i % 2) == 0) ? 1 : 0, efl, BASE, ed);
    end

    // Start ignored in COLLECT and WRITE, honoured in DONE
    sc("s6_start", 1, 2, 'h00, 0, C_COL, BASE, 32'h4433_2211);
    sc("s6_a1", 0, 0, 'hA1, 1, C_COL, BASE, 32'h4433_2211);
    sc("s6_a2", 0, 0, 'hA2, 1, C_COL, BASE, 32'h4433_2211);
    sc("s6_start_in_collect", 1, 0, 'hA3, 1, C_COL, BASE, 32'h4433_2211);
    sc("s6_a4", 0, 0, 'hA4, 1, C_WR, BASE, 32'hA4A3_A2A1);
    sc("s6_start_in_write", 1, 0, 'h00, 0, C_COL, BASE, 32'hA4A3_A2A1);
    sc("s6_b1", 0, 0, 'hB1, 1, C_COL, BASE, 32'hA4A3_A2A1);
    sc("s6_b2", 0, 0, 'hB2, 1, C_COL, BASE, 32'hA4A3_A2A1);
    sc("s6_b3", 0, 0, 'hB3, 1, C_COL, BASE, 32'hA4A3_A2A1);
    sc("s6_b4", 0, 0, 'hB4, 1, C_WR, BASE4, 32'hB4B3_B2B1);
    sc("s6_done", 0, 0, 'h00, 0, C_DONE, BASE4, 32'hB4B3_B2B1);
    sc("s6_restart_from_done", 1, 1, 'h00, 0, C_COL, BASE4, 32'hB4B3_B2B1);
    sc("s6_c1", 0, 0, 'hC1, 1, C_COL, BASE4, 32'hB4B3_B2B1);
    sc("s6_c2", 0, 0, 'hC2, 1, C_COL, BASE4, 32'hB4B3_B2B1);
    sc("s6_c3", 0, 0, 'hC3, 1, C_COL, BASE4, 32'hB4B3_B2B1);
    sc("s6_c4", 0, 0, 'hC4, 1, C_WR, BASE, 32'hC4C3_C2C1);
    sc("s6_done2", 0, 0, 'h00, 0, C_DONE, BASE, 32'hC4C3_C2C1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
